// File: rtl/mpu_poll_sequencer.sv
// mpu_poll_sequencer
// Autonomous front end for the MPU_6050 top: runs a fixed init instruction
// list once, then a fixed read instruction list every sample period. Each
// instruction goes through the I_EN/O_BUSY handshake, is error-checked, and
// is retried a bounded number of times before the sequencer parks in FAULT.
// Read results are presented with their list index and a one-cycle strobe.
module mpu_poll_sequencer #(
    parameter int INSTR_SZ    = 8,
    parameter int RXD_SZ      = 24,
    parameter int INIT_LEN    = 4,
    parameter int READ_LEN    = 3,
    parameter logic [INIT_LEN*INSTR_SZ-1:0] INIT_LIST = {8'h10, 8'h20, 8'h30, 8'h40},
    parameter logic [READ_LEN*INSTR_SZ-1:0] READ_LIST = {8'h56, 8'h78, 8'h9A},
    parameter int PERIOD_CYC  = 50_000,
    parameter int TIMEOUT_CYC = 50_000,
    parameter int RETRY_MAX   = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                I_EN,
    input  logic                I_CLR,
    output logic                O_EN,
    output logic [INSTR_SZ-1:0] O_INSTR,
    input  logic                I_BUSY,
    input  logic                I_ERR,
    input  logic                I_ACK_FL,
    input  logic [RXD_SZ-1:0]   I_RXD,
    output logic [RXD_SZ-1:0]   O_DATA,
    output logic [3:0]          O_IDX,
    output logic                O_VALID,
    output logic                O_INIT_DONE,
    output logic                O_BUSY,
    output logic                O_FAULT,
    output logic                O_OVERRUN,
    output logic [7:0]          O_RETRY_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_PERIOD_WAIT,
        ST_FAULT
    } state_t;

    localparam logic       PH_INIT   = 1'b0;
    localparam logic       PH_READ   = 1'b1;
    localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
    localparam logic [3:0] READ_LAST = 4'(READ_LEN - 1);
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] PER_LAST = 32'(PERIOD_CYC - 1);

    // FSM state and per-instruction bookkeeping
    state_t              r_state;
    logic                r_phase;
    logic [3:0]          r_idx;
    logic [7:0]          r_retry;
    logic                r_err;
    logic                r_tmo;
    logic [31:0]         r_tmo_cnt;
    logic [31:0]         r_per_cnt;

    // Registered outputs
    logic                r_o_en;
    logic [INSTR_SZ-1:0] r_o_instr;
    logic [RXD_SZ-1:0]   r_o_data;
    logic [3:0]          r_o_idx;
    logic                r_o_valid;
    logic                r_init_done;
    logic                r_fault;
    logic                r_overrun;
    logic [7:0]          r_retry_cnt;

    // Instruction lists unpacked into 16-entry tables so a 4-bit index
    // always addresses a defined entry; unused slots read as zero.
    logic [INSTR_SZ-1:0] w_init_rom [16];
    logic [INSTR_SZ-1:0] w_read_rom [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            if (gi < INIT_LEN) begin : g_init
                assign w_init_rom[gi] = INIT_LIST[(INIT_LEN-1-gi)*INSTR_SZ +: INSTR_SZ];
            end else begin : g_init_pad
                assign w_init_rom[gi] = '0;
            end
            if (gi < READ_LEN) begin : g_read
                assign w_read_rom[gi] = READ_LIST[(READ_LEN-1-gi)*INSTR_SZ +: INSTR_SZ];
            end else begin : g_read_pad
                assign w_read_rom[gi] = '0;
            end
        end
    endgenerate

    logic [INSTR_SZ-1:0] w_instr;
    logic                w_last;
    logic                w_pass;
    logic                w_tmo_hit;
    logic                w_tick;
    logic                w_in_burst;
    logic                w_last_done;

    assign w_instr   = (r_phase == PH_READ) ? w_read_rom[r_idx] : w_init_rom[r_idx];
    assign w_last    = (r_phase == PH_READ) ? (r_idx == READ_LAST) : (r_idx == INIT_LAST);
    assign w_pass    = !r_err && !r_tmo;
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_tick    = r_init_done && (r_per_cnt == PER_LAST);

    // A read burst is running from its first issue up to and including the
    // CHECK of its last entry; a tick landing on that final passing CHECK is
    // not an overrun because the burst is finishing on that very edge.
    assign w_in_burst  = (r_phase == PH_READ) &&
                         ((r_state == ST_ISSUE) || (r_state == ST_WAIT_START) ||
                          (r_state == ST_WAIT_DONE) || (r_state == ST_CHECK));
    assign w_last_done = (r_state == ST_CHECK) && (r_phase == PH_READ) && w_last && w_pass;

    // Free-running sample period counter, started once init has completed
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_per_cnt <= '0;
        end else if (r_init_done) begin
            r_per_cnt <= w_tick ? '0 : (r_per_cnt + 32'd1);
        end
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_INIT;
            r_idx       <= '0;
            r_retry     <= '0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_tmo_cnt   <= '0;
            r_o_en      <= 1'b0;
            r_o_instr   <= '0;
            r_o_data    <= '0;
            r_o_idx     <= '0;
            r_o_valid   <= 1'b0;
            r_init_done <= 1'b0;
            r_fault     <= 1'b0;
            r_overrun   <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_o_en    <= 1'b0;
            r_o_valid <= 1'b0;
            r_overrun <= w_tick && w_in_burst && !w_last_done;

            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (I_EN) begin
                        if (!r_init_done) begin
                            r_phase <= PH_INIT;
                            r_idx   <= '0;
                            r_retry <= '0;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_state <= ST_PERIOD_WAIT;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_o_en    <= 1'b1;
                    r_o_instr <= w_instr;
                    r_err     <= 1'b0;
                    r_tmo     <= 1'b0;
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_START;
                end

                // Busy seen while our own strobe is still high cannot be a
                // response to it, so it is ignored for that first cycle.
                ST_WAIT_START: begin
                    if (I_BUSY && !r_o_en) begin
                        r_tmo_cnt <= '0;
                        r_state   <= ST_WAIT_DONE;
                    end else if (w_tmo_hit) begin
                        r_tmo     <= 1'b1;
                        r_state   <= ST_CHECK;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end

                ST_WAIT_DONE: begin
                    r_err <= r_err | I_ERR | I_ACK_FL;
                    if (!I_BUSY) begin
                        r_state   <= ST_CHECK;
                    end else if (w_tmo_hit) begin
                        r_tmo     <= 1'b1;
                        r_state   <= ST_CHECK;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end

                // Dropping I_EN is honoured only here, after the current
                // instruction has fully succeeded or exhausted its retries.
                ST_CHECK: begin
                    r_tmo_cnt <= '0;
                    if (w_pass) begin
                        r_retry <= '0;
                        if (r_phase == PH_READ) begin
                            r_o_data  <= I_RXD;
                            r_o_idx   <= r_idx;
                            r_o_valid <= 1'b1;
                        end
                        if (w_last && (r_phase == PH_INIT)) begin
                            r_init_done <= 1'b1;
                        end
                        if (!I_EN) begin
                            r_state <= ST_IDLE;
                        end else if (w_last) begin
                            r_state <= ST_PERIOD_WAIT;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= ST_ISSUE;
                        end
                    end else if (r_retry < RETRY_LIM) begin
                        r_retry <= r_retry + 8'd1;
                        if (r_retry_cnt != 8'hFF) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end
                        r_state <= ST_ISSUE;
                    end else begin
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end
                end

                ST_PERIOD_WAIT: begin
                    if (!I_EN) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_phase <= PH_READ;
                        r_idx   <= '0;
                        r_retry <= '0;
                        r_state <= ST_ISSUE;
                    end
                end

                ST_FAULT: begin
                    if (I_CLR) begin
                        r_fault <= 1'b0;
                        r_retry <= '0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_EN        = r_o_en;
    assign O_INSTR     = r_o_instr;
    assign O_DATA      = r_o_data;
    assign O_IDX       = r_o_idx;
    assign O_VALID     = r_o_valid;
    assign O_INIT_DONE = r_init_done;
    assign O_FAULT     = r_fault;
    assign O_OVERRUN   = r_overrun;
    assign O_RETRY_CNT = r_retry_cnt;
    // Pure decode of the state register
    assign O_BUSY      = (r_state != ST_IDLE) && (r_state != ST_PERIOD_WAIT) &&
                         (r_state != ST_FAULT);

endmodule

// File: tb/tb_mpu_poll_sequencer.sv
// Testbench for mpu_poll_sequencer: an MPU_6050 stub answers each strobe,
// expected instructions and read results are queued ahead of time and
// popped as the DUT produces them.
module tb_mpu_poll_sequencer;

    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 120;

    logic        CLK;
    logic        RST;
    logic        I_EN;
    logic        I_CLR;
    logic        O_EN;
    logic [7:0]  O_INSTR;
    logic        I_BUSY;
    logic        I_ERR;
    logic        I_ACK_FL;
    logic [23:0] I_RXD;
    logic [23:0] O_DATA;
    logic [3:0]  O_IDX;
    logic        O_VALID;
    logic        O_INIT_DONE;
    logic        O_BUSY;
    logic        O_FAULT;
    logic        O_OVERRUN;
    logic [7:0]  O_RETRY_CNT;

    mpu_poll_sequencer #(
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT),
        .RETRY_MAX   (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .I_EN        (I_EN),
        .I_CLR       (I_CLR),
        .O_EN        (O_EN),
        .O_INSTR     (O_INSTR),
        .I_BUSY      (I_BUSY),
        .I_ERR       (I_ERR),
        .I_ACK_FL    (I_ACK_FL),
        .I_RXD       (I_RXD),
        .O_DATA      (O_DATA),
        .O_IDX       (O_IDX),
        .O_VALID     (O_VALID),
        .O_INIT_DONE (O_INIT_DONE),
        .O_BUSY      (O_BUSY),
        .O_FAULT     (O_FAULT),
        .O_OVERRUN   (O_OVERRUN),
        .O_RETRY_CNT (O_RETRY_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stub configuration, written only by the main sequence
    int         busy_len = 20;
    logic       stub_silent = 1'b0;
    logic [7:0] err_instr = 8'h00;
    logic [7:0] ack_instr = 8'h00;
    int         ack_gen = 0;

    // Stub state, written only by the stub
    int   busy_left;
    int   ack_seen;
    logic cur_err;
    logic cur_ack;

    function automatic logic [23:0] rxd_for(input logic [7:0] instr);
        case (instr)
            8'h56:   return 24'h000000;
            8'h78:   return 24'h111111;
            8'h9A:   return 24'h222222;
            default: return 24'hABCDEF;
        endcase
    endfunction

    // MPU_6050 stand-in: busy for busy_len cycles after each strobe
    always @(negedge CLK) begin
        I_ACK_FL = 1'b0;
        if (RST) begin
            I_BUSY    = 1'b0;
            I_ERR     = 1'b0;
            I_RXD     = '0;
            busy_left = 0;
            cur_err   = 1'b0;
            cur_ack   = 1'b0;
            ack_seen  = ack_gen;
        end else if (O_EN) begin
            I_RXD   = rxd_for(O_INSTR);
            cur_err = (O_INSTR == err_instr);
            cur_ack = (O_INSTR == ack_instr) && (ack_seen != ack_gen);
            if (cur_ack) ack_seen = ack_gen;
            if (!stub_silent) begin
                I_BUSY    = 1'b1;
                busy_left = busy_len;
                I_ERR     = cur_err;
            end
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (cur_ack && (busy_left == busy_len / 2)) I_ACK_FL = 1'b1;
            if (busy_left == 0) begin
                I_BUSY = 1'b0;
                I_ERR  = 1'b0;
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ovr_seen = 0;
    logic [7:0]  exp_instr[$];
    logic [27:0] exp_valid[$];
    int          issue_cycs[$];
    int          burst_cycs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then compare whatever the DUT produced against the scoreboard
    task automatic tick();
        logic [7:0]  ei;
        logic [27:0] ev;
        @(posedge CLK);
        #1;
        cyc++;
        if (O_EN) begin
            issue_cycs.push_back(cyc);
            if (O_INSTR == 8'h56) burst_cycs.push_back(cyc);
            chk("issue_expected", 32'(exp_instr.size() != 0), 32'd1);
            if (exp_instr.size() != 0) begin
                ei = exp_instr.pop_front();
                $display("cyc=%0d issue instr=%02h expected=%02h", cyc, O_INSTR, ei);
                chk("instr", 32'(O_INSTR), 32'(ei));
            end
        end
        if (O_VALID) begin
            chk("valid_expected", 32'(exp_valid.size() != 0), 32'd1);
            if (exp_valid.size() != 0) begin
                ev = exp_valid.pop_front();
                $display("cyc=%0d valid idx=%0d data=%06h expected=%07h", cyc, O_IDX, O_DATA, ev);
                chk("valid_idx_data", 32'({O_IDX, O_DATA}), 32'(ev));
            end
        end
        if (O_OVERRUN) ovr_seen++;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        I_EN  = 1'b0;
        I_CLR = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        exp_instr.delete();
        exp_valid.delete();
        tick();
    endtask

    task automatic push_burst();
        exp_instr.push_back(8'h56);
        exp_instr.push_back(8'h78);
        exp_instr.push_back(8'h9A);
        exp_valid.push_back({4'd0, 24'h000000});
        exp_valid.push_back({4'd1, 24'h111111});
        exp_valid.push_back({4'd2, 24'h222222});
    endtask

    initial begin
        RST   = 1'b1;
        I_EN  = 1'b0;
        I_CLR = 1'b0;

        // Reset state
        do_reset();
        chk("rst_o_en", 32'(O_EN), 32'd0);
        chk("rst_o_valid", 32'(O_VALID), 32'd0);
        chk("rst_init_done", 32'(O_INIT_DONE), 32'd0);
        chk("rst_busy", 32'(O_BUSY), 32'd0);
        chk("rst_fault", 32'(O_FAULT), 32'd0);
        chk("rst_overrun", 32'(O_OVERRUN), 32'd0);
        chk("rst_retry_cnt", 32'(O_RETRY_CNT), 32'd0);
        chk("rst_data", 32'(O_DATA), 32'd0);
        chk("rst_idx", 32'(O_IDX), 32'd0);

        // Init list, clean handshakes, O_EN on the second edge after I_EN
        exp_instr.push_back(8'h10);
        exp_instr.push_back(8'h20);
        exp_instr.push_back(8'h30);
        exp_instr.push_back(8'h40);
        I_EN = 1'b1;
        tick();
        chk("lat_edge1_o_en", 32'(O_EN), 32'd0);
        chk("lat_edge1_busy", 32'(O_BUSY), 32'd1);
        tick();
        chk("lat_edge2_o_en", 32'(O_EN), 32'd1);
        for (int i = 0; i < 1000 && !O_INIT_DONE; i++) tick();
        chk("init_done", 32'(O_INIT_DONE), 32'd1);
        chk("init_all_issued", 32'(exp_instr.size()), 32'd0);
        chk("init_retry_cnt", 32'(O_RETRY_CNT), 32'd0);

        // Two periodic read bursts
        ovr_seen = 0;
        burst_cycs.delete();
        push_burst();
        push_burst();
        for (int i = 0; i < 1200 && exp_valid.size() != 0; i++) tick();
        chk("read_valids_done", 32'(exp_valid.size()), 32'd0);
        chk("read_burst_count", 32'(burst_cycs.size()), 32'd2);
        if (burst_cycs.size() >= 2)
            chk("read_period", 32'(burst_cycs[1] - burst_cycs[0]), 32'(PERIOD));
        chk("read_no_overrun", 32'(ovr_seen), 32'd0);
        tick();
        chk("read_idle_between", 32'(O_BUSY), 32'd0);
        I_EN = 1'b0;
        repeat (2) tick();

        // Long busy: bursts outlast the period, then I_EN dropped mid-burst
        busy_len = 100;
        ovr_seen = 0;
        I_EN = 1'b1;
        push_burst();
        push_burst();
        for (int i = 0; i < 3000 && exp_valid.size() != 0; i++) tick();
        chk("slow_valids_done", 32'(exp_valid.size()), 32'd0);
        chk("slow_overrun_seen", 32'(ovr_seen >= 1), 32'd1);
        exp_instr.push_back(8'h56);
        exp_valid.push_back({4'd0, 24'h000000});
        for (int i = 0; i < 600 && exp_instr.size() != 0; i++) tick();
        chk("drop_first_issued", 32'(exp_instr.size()), 32'd0);
        repeat (10) tick();
        I_EN = 1'b0;
        for (int i = 0; i < 300 && exp_valid.size() != 0; i++) tick();
        chk("drop_valid_done", 32'(exp_valid.size()), 32'd0);
        repeat (2) tick();
        chk("drop_busy_low", 32'(O_BUSY), 32'd0);
        repeat (400) tick();
        chk("drop_stays_idle", 32'(O_BUSY), 32'd0);

        // Retry: ACK failure on the first attempt of init entry 1
        busy_len = 20;
        do_reset();
        ack_instr = 8'h20;
        ack_gen++;
        exp_instr.push_back(8'h10);
        exp_instr.push_back(8'h20);
        exp_instr.push_back(8'h20);
        exp_instr.push_back(8'h30);
        exp_instr.push_back(8'h40);
        I_EN = 1'b1;
        for (int i = 0; i < 1000 && !O_INIT_DONE; i++) tick();
        I_EN = 1'b0;
        chk("retry_init_done", 32'(O_INIT_DONE), 32'd1);
        chk("retry_all_issued", 32'(exp_instr.size()), 32'd0);
        chk("retry_cnt", 32'(O_RETRY_CNT), 32'd1);
        chk("retry_no_fault", 32'(O_FAULT), 32'd0);
        repeat (3) tick();

        // Fault: I_ERR held on entry 0, then I_CLR restarts init
        ack_instr = 8'h00;
        do_reset();
        err_instr = 8'h10;
        repeat (4) exp_instr.push_back(8'h10);
        I_EN = 1'b1;
        for (int i = 0; i < 1000 && !O_FAULT; i++) tick();
        chk("fault_set", 32'(O_FAULT), 32'd1);
        chk("fault_issues", 32'(exp_instr.size()), 32'd0);
        chk("fault_retry_cnt", 32'(O_RETRY_CNT), 32'd3);
        chk("fault_init_done", 32'(O_INIT_DONE), 32'd0);
        repeat (20) tick();
        chk("fault_sticky", 32'(O_FAULT), 32'd1);
        chk("fault_not_busy", 32'(O_BUSY), 32'd0);
        err_instr = 8'h00;
        exp_instr.push_back(8'h10);
        exp_instr.push_back(8'h20);
        exp_instr.push_back(8'h30);
        exp_instr.push_back(8'h40);
        I_CLR = 1'b1;
        tick();
        I_CLR = 1'b0;
        chk("clr_fault_low", 32'(O_FAULT), 32'd0);
        for (int i = 0; i < 1000 && !O_INIT_DONE; i++) tick();
        I_EN = 1'b0;
        chk("clr_init_done", 32'(O_INIT_DONE), 32'd1);
        chk("clr_all_issued", 32'(exp_instr.size()), 32'd0);
        repeat (3) tick();

        // Timeout: stub never answers
        do_reset();
        stub_silent = 1'b1;
        issue_cycs.delete();
        repeat (4) exp_instr.push_back(8'h10);
        I_EN = 1'b1;
        for (int i = 0; i < 2000 && !O_FAULT; i++) tick();
        chk("tmo_fault", 32'(O_FAULT), 32'd1);
        chk("tmo_issue_count", 32'(issue_cycs.size()), 32'd4);
        chk("tmo_retry_cnt", 32'(O_RETRY_CNT), 32'd3);
        if (issue_cycs.size() >= 2) begin
            chk("tmo_interval_min", 32'((issue_cycs[1] - issue_cycs[0]) >= TIMEOUT), 32'd1);
            chk("tmo_interval_max", 32'((issue_cycs[1] - issue_cycs[0]) <= TIMEOUT + 4), 32'd1);
        end
        repeat (50) tick();
        chk("tmo_no_more_issue", 32'(issue_cycs.size()), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
